// File: rtl/wisc_pkg.sv
// Shared WISC definitions used by the fetch front end and the decode-stage
// next-PC logic: opcode constants, the NOP encoding and the fetch FSM states.
package wisc_pkg;

  localparam logic [3:0]  OPC_HLT   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder.
// Ports: a, b - operands; cin - carry in; sum - a + b + cin (mod 2^16);
//        cout - carry out of bit 15.
module rca_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[16];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end for the 16-bit WISC pipeline.
// Owns the PC, keeps exactly one instruction-memory read outstanding, and
// hands fetched words to decode through a one-entry valid/ready slot.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   imem_req / imem_addr       - one-cycle read request, address = PC
//   imem_valid / imem_data     - returned instruction word
//   id_ready                   - decode consumes the slot this cycle
//   if_valid / if_instr /
//   if_pc / if_pc_plus2        - output slot contents
//   redirect_valid/redirect_pc - taken branch/jump from decode next-PC logic
//   halted                     - fetch stopped on HLT
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = OPC_HLT,
  parameter logic [15:0] NOP_INSTR   = wisc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_plus2;
  logic         squash;
  logic         slot_free;
  logic         carry_unused;

  rca_16bit u_pc_adder (
    .a    (pc),
    .b    (16'h0002),
    .cin  (1'b0),
    .sum  (pc_plus2),
    .cout (carry_unused)
  );

  // The slot counts as free when decode takes it this cycle, so a request
  // can be issued in the same cycle id_ready rises.
  always_comb begin
    slot_free = !if_valid || id_ready;
    imem_req  = !rst && (state == FETCH) && slot_free && !redirect_valid;
    imem_addr = pc;
    halted    = (state == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus2 <= '0;
    end else begin
      if (if_valid && id_ready) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end

      if (redirect_valid) begin
        pc       <= redirect_pc;
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
        case (state)
          WAIT: begin
            // Data arriving with the redirect is wrong-path; otherwise the
            // pending read must be dropped when it eventually returns.
            if (imem_valid) begin
              state  <= FETCH;
              squash <= 1'b0;
            end else begin
              squash <= 1'b1;
            end
          end
          HALTED:  state <= FETCH;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (slot_free) state <= WAIT;
          end
          WAIT: begin
            if (imem_valid) begin
              if (squash) begin
                squash <= 1'b0;
                state  <= FETCH;
              end else begin
                if_valid    <= 1'b1;
                if_instr    <= imem_data;
                if_pc       <= pc;
                if_pc_plus2 <= pc_plus2;
                if (imem_data[15:12] == HALT_OPCODE) begin
                  state <= HALTED;
                end else begin
                  pc    <= pc_plus2;
                  state <= FETCH;
                end
              end
            end
          end
          HALTED:  state <= HALTED;
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected request
// addresses and expected slot contents; monitors pop and compare.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] plus2;
  } slot_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_addr[$];
  slot_t       exp_slot[$];

  logic        mem_auto;
  int          mem_lat;
  logic        pend;
  int          cnt;
  logic [15:0] paddr;
  logic        prev_req;

  fetch_unit #(
    .RESET_PC    (16'h0000),
    .HALT_OPCODE (4'hF),
    .NOP_INSTR   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_data      (imem_data),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      16'h0004: return 16'h9ABC;
      16'h0010: return 16'hF000;
      16'h0020: return 16'h2020;
      16'h0040: return 16'h4040;
      16'h0042: return 16'h4242;
      16'hFFFE: return 16'h1111;
      default:  return 16'h0BAD;
    endcase
  endfunction

  // Memory model: capture request, return data mem_lat cycles later.
  always @(negedge clk) begin
    if (imem_req && mem_auto) begin
      pend  = 1'b1;
      cnt   = mem_lat;
      paddr = imem_addr;
    end
  end

  initial begin
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        imem_valid = 1'b0;
        if (pend && cnt == 1) begin
          imem_valid = 1'b1;
          imem_data  = mem_read(paddr);
          pend       = 1'b0;
        end else if (pend) begin
          cnt--;
        end
      end
    end
  end

  // Request monitor: address order and single-cycle pulses.
  always @(negedge clk) begin
    if (imem_req) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req act=%h exp=none", imem_addr);
      end else begin
        chk("req_addr", imem_addr, exp_addr.pop_front());
      end
      if (prev_req) chk("req_pulse", 16'(prev_req), 16'h0000);
    end
    prev_req = imem_req;
  end

  // Slot monitor: compare each consumed instruction with the scoreboard.
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready) begin
      if (exp_slot.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slot act=%h exp=none", if_instr);
      end else begin
        slot_t s;
        s = exp_slot.pop_front();
        chk("slot_instr", if_instr, s.instr);
        chk("slot_pc", if_pc, s.pc);
        chk("slot_plus2", if_pc_plus2, s.plus2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [15:0] a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_req act=none exp=%h", a);
    end
  endtask

  task automatic push_slot(input logic [15:0] i, input logic [15:0] p, input logic [15:0] p2);
    slot_t s;
    s.instr = i;
    s.pc    = p;
    s.plus2 = p2;
    exp_slot.push_back(s);
  endtask

  initial begin
    rst            = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    imem_valid     = 1'b0;
    imem_data      = 16'h0000;
    mem_auto       = 1'b1;
    mem_lat        = 1;
    prev_req       = 1'b0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_req", 16'(imem_req), 16'h0000);
    chk("rst_valid", 16'(if_valid), 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_plus2", if_pc_plus2, 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);

    // Back-to-back fetch with 1-cycle memory, then stall with slot full.
    exp_addr.push_back(16'h0000);
    exp_addr.push_back(16'h0002);
    exp_addr.push_back(16'h0004);
    push_slot(16'h1234, 16'h0000, 16'h0002);
    push_slot(16'h5678, 16'h0002, 16'h0004);
    step();
    rst = 1'b0;
    wait_req(16'h0002);
    step();
    id_ready = 1'b0;
    mem_lat  = 3;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 16'(if_valid), 16'h0001);
      chk("stall_instr", if_instr, 16'h5678);
      chk("stall_pc", if_pc, 16'h0002);
      chk("stall_plus2", if_pc_plus2, 16'h0004);
      chk("stall_noreq", 16'(imem_req), 16'h0000);
      step();
    end
    id_ready = 1'b1;
    @(negedge clk);
    chk("resume_req_same_cycle", 16'(imem_req), 16'h0001);

    // Redirect one cycle after the request to 4 (latency 3): word dropped.
    exp_addr.push_back(16'h0040);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("squash_slot_empty", 16'(if_valid), 16'h0000);
    push_slot(16'h4040, 16'h0040, 16'h0042);
    exp_addr.push_back(16'h0042);
    exp_addr.push_back(16'h0010);
    wait_req(16'h0040);

    // Redirect in the same cycle as imem_valid for the request to 0x42.
    wait_req(16'h0042);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    mem_lat        = 1;
    @(negedge clk);
    chk("same_cycle_imem_valid", 16'(imem_valid), 16'h0001);
    push_slot(16'hF000, 16'h0010, 16'h0012);
    step();
    redirect_valid = 1'b0;

    // HLT fetched at 0x10.
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (halted) begin
          seen = 1'b1;
          break;
        end
      end
      chk("halt_reached", 16'(seen), 16'h0001);
    end
    chk("halt_instr", if_instr, 16'hF000);
    chk("halt_pc_hold", imem_addr, 16'h0010);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("halt_stays", 16'(halted), 16'h0001);
      chk("halt_noreq", 16'(imem_req), 16'h0000);
    end
    exp_addr.push_back(16'h0020);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("unhalt", 16'(halted), 16'h0000);
    chk("unhalt_req", 16'(imem_req), 16'h0001);

    // Slot holding 0x2020 is flushed by a redirect to 0xFFFE.
    step();
    id_ready = 1'b0;
    step();
    @(negedge clk);
    chk("hold_2020", if_instr, 16'h2020);
    exp_addr.push_back(16'hFFFE);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 16'(if_valid), 16'h0000);
    chk("flush_instr", if_instr, 16'h0000);
    push_slot(16'h1111, 16'hFFFE, 16'h0000);
    step();
    step();
    @(negedge clk);
    chk("wrap_pc", if_pc, 16'hFFFE);
    chk("wrap_plus2", if_pc_plus2, 16'h0000);
    chk("wrap_next_addr", imem_addr, 16'h0000);

    // Reset while waiting; the late response must be ignored.
    exp_addr.push_back(16'h0000);
    step();
    id_ready = 1'b1;
    mem_auto = 1'b0;
    @(negedge clk);
    chk("wrap_req", 16'(imem_req), 16'h0001);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_noreq", 16'(imem_req), 16'h0000);
    exp_addr.push_back(16'h0000);
    push_slot(16'h1234, 16'h0000, 16'h0002);
    step();
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_data  = 16'hF0F0;
    @(negedge clk);
    chk("rst2_valid", 16'(if_valid), 16'h0000);
    chk("rst2_pc", if_pc, 16'h0000);
    chk("rst2_plus2", if_pc_plus2, 16'h0000);
    chk("rst2_halted", 16'(halted), 16'h0000);
    chk("rst2_addr", imem_addr, 16'h0000);
    step();
    imem_valid = 1'b0;
    @(negedge clk);
    chk("late_valid_ignored", 16'(if_valid), 16'h0000);
    step();
    imem_valid = 1'b1;
    imem_data  = 16'h1234;
    exp_addr.push_back(16'h0002);
    step();
    imem_valid = 1'b0;
    repeat (4) step();

    chk("addr_queue_empty", 16'(exp_addr.size()), 16'h0000);
    chk("slot_queue_empty", 16'(exp_slot.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
